// File: rtl/alu_pkg.sv
// Shared ALU opcodes, execution FSM encoding and opcode helpers for the 24-bit core.
// Imported by alu_exec_unit, alu_shift_unit and alu_control.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0101;
    localparam logic [3:0] ALU_SRLV = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_BNEQ = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1110;
    localparam logic [3:0] ALU_SLL  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SRLV) || (code == ALU_SRL) || (code == ALU_SLL);
    endfunction

    function automatic logic is_left_shift(input logic [3:0] code);
        return code == ALU_SLL;
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shifter for SRL/SLL: iterative 1 bit/cycle by default, or a single-cycle
// barrel shifter when ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               shift_left,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               need_iter,
    output logic               last,
    output logic [WIDTH-1:0]   imm_result,
    output logic [WIDTH-1:0]   next_result
);

`ifdef ALU_BARREL_SHIFT_EN

    // Whole shift resolves at the accept edge; shifting by >= WIDTH yields 0.
    always_comb begin
        need_iter   = 1'b0;
        last        = 1'b0;
        next_result = '0;
        imm_result  = shift_left ? (a << shamt) : (a >> shamt);
    end

`else

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [CNT_W-1:0] k_eff;

    // Saturate the amount at WIDTH so oversized shifts clear the word.
    always_comb begin
        if (32'(shamt) >= 32'(WIDTH)) begin
            k_eff = CNT_W'(WIDTH);
        end else begin
            k_eff = CNT_W'(shamt);
        end
    end

    always_comb begin
        need_iter   = (k_eff != '0);
        imm_result  = a;
        last        = (cnt_q == CNT_W'(1));
        next_result = left_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    end

    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        left_d = left_q;
        if (start) begin
            work_d = a;
            cnt_d  = k_eff;
            left_d = shift_left;
        end else if (step && (cnt_q != '0)) begin
            work_d = next_result;
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
        end
    end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready in, registered result bundle out.
// Build option ALU_BARREL_SHIFT_EN makes shifts single-cycle (handled in alu_shift_unit).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             branch_q, branch_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             op_is_shift;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_branch;
    logic             alu_illegal;

    logic             sh_start;
    logic             sh_step;
    logic             sh_need_iter;
    logic             sh_last;
    logic [WIDTH-1:0] sh_imm_result;
    logic [WIDTH-1:0] sh_next_result;

    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_branch;
    logic             load_illegal;

    assign op_is_shift = is_shift(alu_cnt);
    assign accept      = in_valid && in_ready;
    assign sh_start    = accept && op_is_shift;
    assign sh_step     = (state_q == ST_SHIFT);

    alu_shift_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk         (clk),
        .reset       (reset),
        .start       (sh_start),
        .shift_left  (is_left_shift(alu_cnt)),
        .step        (sh_step),
        .a           (a),
        .shamt       (b[SHAMT_W-1:0]),
        .need_iter   (sh_need_iter),
        .last        (sh_last),
        .imm_result  (sh_imm_result),
        .next_result (sh_next_result)
    );

    // Single-cycle ops; shift codes are listed so they do not fall into illegal.
    always_comb begin
        diff        = a - b;
        alu_res     = '0;
        alu_branch  = 1'b0;
        alu_illegal = 1'b0;
        case (alu_cnt)
            ALU_AND:  alu_res = a & b;
            ALU_OR:   alu_res = a | b;
            ALU_XOR:  alu_res = a ^ b;
            ALU_NOR:  alu_res = ~(a | b);
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = diff;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_BEQ: begin
                alu_res    = diff;
                alu_branch = (diff == '0);
            end
            ALU_BNEQ: begin
                alu_res    = diff;
                alu_branch = (diff != '0);
            end
            ALU_SRLV, ALU_SRL, ALU_SLL: alu_res = '0;
            default:  alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_is_shift && sh_need_iter) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The bundle is captured once: at accept for one-cycle ops, on the last shift step otherwise.
    always_comb begin
        load         = 1'b0;
        load_res     = '0;
        load_branch  = 1'b0;
        load_illegal = 1'b0;
        if ((state_q == ST_IDLE) && accept) begin
            if (op_is_shift) begin
                load     = !sh_need_iter;
                load_res = sh_imm_result;
            end else begin
                load         = 1'b1;
                load_res     = alu_res;
                load_branch  = alu_branch;
                load_illegal = alu_illegal;
            end
        end else if ((state_q == ST_SHIFT) && sh_last) begin
            load     = 1'b1;
            load_res = sh_next_result;
        end

        result_d  = result_q;
        zero_d    = zero_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;
        if (load) begin
            result_d  = load_res;
            zero_d    = (load_res == '0);
            branch_d  = load_branch;
            illegal_d = load_illegal;
        end
    end

    always_comb begin
        in_ready     = (state_q == ST_IDLE) && !reset;
        out_valid    = (state_q == ST_DONE);
        result       = result_q;
        zero         = zero_q;
        branch_taken = branch_q;
        illegal      = illegal_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops
// checked against an arithmetic reference model (honours ALU_BARREL_SHIFT_EN).
module tb_alu_exec_unit;

    localparam int WIDTH = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_cnt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;
    logic             illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(
        .WIDTH   (WIDTH),
        .SHAMT_W (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_cnt      (alu_cnt),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model built from plain integer arithmetic on the operand values.
    function automatic void refModel(input logic [3:0] code, input logic [23:0] opa, input logic [23:0] opb,
                                     output logic [23:0] res, output logic br, output logic ill, output int lat);
        longint ua, ub, m, sa, sb, p;
        int     k;
        m   = 64'd1 << WIDTH;
        ua  = opa;
        ub  = opb;
        k   = int'(opb[4:0]);
        if (k > WIDTH) k = WIDTH;
        p   = 1;
        for (int i = 0; i < k; i++) p = p * 2;
        res = '0;
        br  = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (code)
            4'd0:  res = opa & opb;
            4'd1:  res = opa | opb;
            4'd2:  res = opa ^ opb;
            4'd3:  res = ~(opa | opb);
            4'd4:  res = 24'((ua + ub) % m);
            4'd5:  res = 24'((ua - ub + m) % m);
            4'd7: begin
                sa  = (ua >= m / 2) ? ua - m : ua;
                sb  = (ub >= m / 2) ? ub - m : ub;
                res = (sa < sb) ? 24'd1 : 24'd0;
            end
            4'd8: begin
                res = 24'((ua - ub + m) % m);
                br  = (ua == ub);
            end
            4'd9: begin
                res = 24'((ua - ub + m) % m);
                br  = (ua != ub);
            end
            4'd6, 4'd14, 4'd15: begin
                if (code == 4'd15) res = 24'((ua * p) % m);
                else               res = 24'(ua / p);
`ifdef ALU_BARREL_SHIFT_EN
                lat = 1;
`else
                lat = k + 1;
`endif
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] code, input logic [23:0] opa, input logic [23:0] opb, input int hold);
        logic [23:0] exp_res;
        logic        exp_br;
        logic        exp_ill;
        int          exp_lat;
        int          lat;
        logic        busy_ok;
        string       t;
        t = $sformatf("op%h_a%h_b%h", code, opa, opb);
        refModel(code, opa, opb, exp_res, exp_br, exp_ill, exp_lat);

        alu_cnt  = code;
        a        = opa;
        b        = opb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_cnt  = 4'($urandom);
        a        = 24'($urandom);
        b        = 24'($urandom);

        lat     = 1;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;

        checkOutput({t, "_latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({t, "_in_ready_busy"}, 32'(busy_ok), 32'd1);
        checkOutput({t, "_result"}, 32'(result), 32'(exp_res));
        checkOutput({t, "_zero"}, 32'(zero), 32'(exp_res == 24'd0));
        checkOutput({t, "_branch"}, 32'(branch_taken), 32'(exp_br));
        checkOutput({t, "_illegal"}, 32'(illegal), 32'(exp_ill));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({t, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({t, "_hold_result"}, 32'(result), 32'(exp_res));
            checkOutput({t, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({t, "_release_valid"}, 32'(out_valid), 32'd0);
        checkOutput({t, "_release_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_cnt   = '0;
        a         = '0;
        b         = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", {29'd0, zero, branch_taken, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(4'b0100, 24'hFFFFFF, 24'd1, 0);
        applyStimulus(4'b0101, 24'd5, 24'd7, 0);
        applyStimulus(4'b0111, 24'h800000, 24'd1, 0);
        applyStimulus(4'b1000, 24'h00ABCD, 24'h00ABCD, 0);
        applyStimulus(4'b1001, 24'h00ABCD, 24'h00ABCD, 0);
        applyStimulus(4'b1111, 24'd1, 24'd5, 0);
        applyStimulus(4'b1110, 24'h800000, 24'd31, 0);
        applyStimulus(4'b1110, 24'h800000, 24'd0, 0);
        applyStimulus(4'b0110, 24'hF0F0F0, 24'd4, 1);
        applyStimulus(4'b1011, 24'h123456, 24'h654321, 0);
        applyStimulus(4'b0101, 24'h000100, 24'h000001, 4);

        // Abort a shift by 10 partway through.
        alu_cnt  = 4'b1111;
        a        = 24'd1;
        b        = 24'd10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midshift_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midshift_reset_result", 32'(result), 32'd0);
        checkOutput("midshift_reset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("midshift_post_reset_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(4'b0010, 24'hAAAAAA, 24'h555555, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  rc;
            logic [23:0] ra;
            logic [23:0] rb;
            rc = 4'($urandom_range(0, 15));
            ra = 24'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 31)) : 24'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            applyStimulus(rc, ra, rb, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
